// File: rtl/mem_ctrl.sv
// Shares one byte-wide RAM port between instruction fetch (IC) and the store/load buffer (SLB).
// Keeps one pending slot per side, grants round-robin, and runs each access byte-serially.
module mem_ctrl #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned NICK_W = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rdy,
  input  logic              clr,
  input  logic              iIC_en,
  input  logic [ADDR_W-1:0] iIC_addr,
  output logic              oIC_en,
  output logic [31:0]       oIC_dt,
  output logic              oIC_busy,
  input  logic              iSLB_en,
  input  logic              iSLB_ls,
  input  logic [NICK_W-1:0] iSLB_nick,
  input  logic [1:0]        iSLB_len,
  input  logic              iSLB_sext,
  input  logic [ADDR_W-1:0] iSLB_addr,
  input  logic [31:0]       iSLB_dt,
  output logic              oSLB_en,
  output logic [NICK_W-1:0] oSLB_nick,
  output logic [31:0]       oSLB_dt,
  output logic              oSLB_busy,
  input  logic [7:0]        mem_din,
  output logic [7:0]        mem_dout,
  output logic [ADDR_W-1:0] mem_a,
  output logic              mem_wr
);

  typedef enum logic [1:0] {StIdle, StRead, StWrite} state_e;

  state_e              state_q;
  logic [2:0]          step_q;
  logic                serve_ic_q;
  logic                last_ic_q;
  logic                wr_q;
  logic [31:0]         buf_q;

  logic                ic_busy_q;
  logic [ADDR_W-1:0]   ic_addr_q;

  logic                slb_busy_q;
  logic                slb_ls_q;
  logic                slb_sext_q;
  logic [1:0]          slb_len_q;
  logic [NICK_W-1:0]   slb_nick_q;
  logic [ADDR_W-1:0]   slb_addr_q;
  logic [31:0]         slb_dt_q;

  logic [2:0]          cur_n;
  logic [ADDR_W-1:0]   cur_base;
  logic [ADDR_W-1:0]   nxt_addr;
  logic                active;
  logic                more_bytes;
  logic                rd_done;
  logic                wr_done;
  logic                abort;
  logic                release_acc;
  logic                free;
  logic                ic_acc;
  logic                slb_acc;
  logic                ic_cand;
  logic                slb_cand;
  logic                grant;
  logic                pick_ic;
  logic                g_store;
  logic [ADDR_W-1:0]   g_addr;
  logic [31:0]         g_dt;
  logic [1:0]          rd_idx;
  logic [1:0]          wr_idx;
  logic [31:0]         rd_word;
  logic [31:0]         rd_fmt;
  logic [7:0]          wr_byte;

  function automatic logic [2:0] nbytes(input logic [1:0] len);
    return (len == 2'd0) ? 3'd1 : (len == 2'd1) ? 3'd2 : 3'd4;
  endfunction

  always_comb begin
    cur_n       = serve_ic_q ? 3'd4 : nbytes(slb_len_q);
    cur_base    = serve_ic_q ? ic_addr_q : slb_addr_q;
    nxt_addr    = cur_base + ADDR_W'(step_q + 3'd1);
    active      = (state_q != StIdle);
    more_bytes  = ((step_q + 3'd1) < cur_n);
    rd_done     = (state_q == StRead) && (step_q == cur_n);
    wr_done     = (state_q == StWrite) && !more_bytes;
    abort       = (state_q == StRead) && clr;
    release_acc = rd_done || wr_done || abort;
    // The slot finishing this edge can hand the port straight to the next request.
    free        = !active || release_acc;

    ic_acc   = iIC_en && !ic_busy_q && !clr;
    slb_acc  = iSLB_en && !slb_busy_q && !(clr && !iSLB_ls);
    ic_cand  = (ic_busy_q && !clr && !(active && serve_ic_q)) || ic_acc;
    slb_cand = (slb_busy_q && !(clr && !slb_ls_q) && !(active && !serve_ic_q)) || slb_acc;
    grant    = free && (ic_cand || slb_cand);
    pick_ic  = ic_cand && !(slb_cand && last_ic_q);

    g_store = !pick_ic && (slb_busy_q ? slb_ls_q : iSLB_ls);
    g_dt    = slb_busy_q ? slb_dt_q : iSLB_dt;
    if (pick_ic) g_addr = ic_busy_q ? ic_addr_q : iIC_addr;
    else         g_addr = slb_busy_q ? slb_addr_q : iSLB_addr;

    // Data on mem_din belongs to the address driven one cycle earlier.
    rd_idx  = step_q[1:0] - 2'd1;
    rd_word = buf_q;
    rd_word[8*rd_idx +: 8] = mem_din;
    case (cur_n)
      3'd1:    rd_fmt = {{24{slb_sext_q & rd_word[7]}}, rd_word[7:0]};
      3'd2:    rd_fmt = {{16{slb_sext_q & rd_word[15]}}, rd_word[15:0]};
      default: rd_fmt = rd_word;
    endcase

    wr_idx  = step_q[1:0] + 2'd1;
    wr_byte = slb_dt_q[8*wr_idx +: 8];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= StIdle;
      step_q     <= '0;
      serve_ic_q <= 1'b0;
      last_ic_q  <= 1'b1;
      wr_q       <= 1'b0;
      buf_q      <= '0;
      ic_busy_q  <= 1'b0;
      ic_addr_q  <= '0;
      slb_busy_q <= 1'b0;
      slb_ls_q   <= 1'b0;
      slb_sext_q <= 1'b0;
      slb_len_q  <= '0;
      slb_nick_q <= '0;
      slb_addr_q <= '0;
      slb_dt_q   <= '0;
      mem_a      <= '0;
      mem_dout   <= '0;
      oIC_en     <= 1'b0;
      oIC_dt     <= '0;
      oSLB_en    <= 1'b0;
      oSLB_dt    <= '0;
      oSLB_nick  <= '0;
    end else if (rdy) begin
      oIC_en  <= 1'b0;
      oSLB_en <= 1'b0;

      if (ic_acc) begin
        ic_busy_q <= 1'b1;
        ic_addr_q <= iIC_addr;
      end else if (clr || (release_acc && serve_ic_q)) begin
        ic_busy_q <= 1'b0;
      end

      if (slb_acc) begin
        slb_busy_q <= 1'b1;
        slb_ls_q   <= iSLB_ls;
        slb_sext_q <= iSLB_sext;
        slb_len_q  <= iSLB_len;
        slb_nick_q <= iSLB_nick;
        slb_addr_q <= iSLB_addr;
        slb_dt_q   <= iSLB_dt;
      end else if ((release_acc && !serve_ic_q) || (clr && !slb_ls_q)) begin
        slb_busy_q <= 1'b0;
      end

      case (state_q)
        StRead: begin
          if (abort) begin
            state_q <= StIdle;
          end else begin
            if (more_bytes) mem_a <= nxt_addr;
            if (step_q != 3'd0) buf_q <= rd_word;
            step_q <= step_q + 3'd1;
            if (rd_done) begin
              state_q <= StIdle;
              if (serve_ic_q) begin
                oIC_en <= 1'b1;
                oIC_dt <= rd_word;
              end else begin
                oSLB_en   <= 1'b1;
                oSLB_dt   <= rd_fmt;
                oSLB_nick <= slb_nick_q;
              end
            end
          end
        end
        StWrite: begin
          if (wr_done) begin
            wr_q    <= 1'b0;
            state_q <= StIdle;
          end else begin
            mem_a    <= nxt_addr;
            mem_dout <= wr_byte;
            step_q   <= step_q + 3'd1;
          end
        end
        default: ;
      endcase

      if (grant) begin
        state_q    <= g_store ? StWrite : StRead;
        step_q     <= '0;
        serve_ic_q <= pick_ic;
        last_ic_q  <= pick_ic;
        mem_a      <= g_addr;
        buf_q      <= '0;
        if (g_store) begin
          mem_dout <= g_dt[7:0];
          wr_q     <= 1'b1;
        end
      end
    end
  end

  assign oIC_busy  = ic_busy_q;
  assign oSLB_busy = slb_busy_q;
  assign mem_wr    = wr_q & rdy;

endmodule

// File: tb/tb_mem_ctrl.sv
// Scoreboard bench for mem_ctrl: stimulus pushes expected results and RAM writes,
// a negedge monitor pops and compares whenever the DUT presents one.
module tb_mem_ctrl;

  logic        clk = 1'b0;
  logic        rst, rdy, clr;
  logic        iIC_en;
  logic [31:0] iIC_addr;
  logic        oIC_en;
  logic [31:0] oIC_dt;
  logic        oIC_busy;
  logic        iSLB_en, iSLB_ls, iSLB_sext;
  logic [3:0]  iSLB_nick;
  logic [1:0]  iSLB_len;
  logic [31:0] iSLB_addr, iSLB_dt;
  logic        oSLB_en;
  logic [3:0]  oSLB_nick;
  logic [31:0] oSLB_dt;
  logic        oSLB_busy;
  logic [7:0]  mem_din, mem_dout;
  logic [31:0] mem_a;
  logic        mem_wr;

  mem_ctrl #(.ADDR_W(32), .NICK_W(4)) dut (
    .clk(clk), .rst(rst), .rdy(rdy), .clr(clr),
    .iIC_en(iIC_en), .iIC_addr(iIC_addr), .oIC_en(oIC_en), .oIC_dt(oIC_dt),
    .oIC_busy(oIC_busy),
    .iSLB_en(iSLB_en), .iSLB_ls(iSLB_ls), .iSLB_nick(iSLB_nick), .iSLB_len(iSLB_len),
    .iSLB_sext(iSLB_sext), .iSLB_addr(iSLB_addr), .iSLB_dt(iSLB_dt),
    .oSLB_en(oSLB_en), .oSLB_nick(oSLB_nick), .oSLB_dt(oSLB_dt), .oSLB_busy(oSLB_busy),
    .mem_din(mem_din), .mem_dout(mem_dout), .mem_a(mem_a), .mem_wr(mem_wr)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          cyc;
    logic [31:0] data;
    logic [31:0] aux;
  } exp_t;

  exp_t ic_q[$];
  exp_t slb_q[$];
  exp_t wr_q[$];
  exp_t me;

  logic [7:0] ram [0:65535];
  int  cyc = 0;
  int  n_chk = 0;
  int  n_fail = 0;
  bit  mon_on = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  // Read port stalls with the rest of the system while rdy is low.
  always @(posedge clk) if (rdy) mem_din <= ram[mem_a[15:0]];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [7:0] fill(input int i);
    logic [31:0] u;
    u = i;
    return u[7:0] ^ u[15:8] ^ 8'h5A;
  endfunction

  function automatic logic [31:0] ram_word(input logic [31:0] a);
    logic [31:0] w;
    logic [31:0] ak;
    w = '0;
    for (int k = 0; k < 4; k++) begin
      ak = a + k;
      w[8*k +: 8] = ram[ak[15:0]];
    end
    return w;
  endfunction

  task automatic next_cycle(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
      iIC_en  = 1'b0;
      iSLB_en = 1'b0;
      clr     = 1'b0;
    end
  endtask

  task automatic ic_req(input logic [31:0] a);
    iIC_en   = 1'b1;
    iIC_addr = a;
  endtask

  task automatic slb_req(input logic ls, input logic [1:0] len, input logic sx,
                         input logic [3:0] nick, input logic [31:0] a, input logic [31:0] d);
    iSLB_en   = 1'b1;
    iSLB_ls   = ls;
    iSLB_len  = len;
    iSLB_sext = sx;
    iSLB_nick = nick;
    iSLB_addr = a;
    iSLB_dt   = d;
  endtask

  task automatic exp_ic(input int c, input logic [31:0] d);
    ic_q.push_back('{cyc: c, data: d, aux: 32'd0});
  endtask

  task automatic exp_slb(input int c, input logic [31:0] d, input logic [31:0] nick);
    slb_q.push_back('{cyc: c, data: d, aux: nick});
  endtask

  task automatic exp_wr(input int c, input logic [31:0] a, input logic [7:0] b);
    wr_q.push_back('{cyc: c, data: {24'd0, b}, aux: a});
  endtask

  always @(negedge clk) begin
    if (!rst && mon_on) begin
      if (oIC_en || oSLB_en) chk("one_result_per_cycle", {31'd0, oIC_en & oSLB_en}, 32'd0);
      if (oIC_en) begin
        chk("ic_result_expected", (ic_q.size() > 0) ? 32'd1 : 32'd0, 32'd1);
        if (ic_q.size() > 0) begin
          me = ic_q.pop_front();
          chk("ic_cycle", cyc, me.cyc);
          chk("ic_data", oIC_dt, me.data);
        end
      end
      if (oSLB_en) begin
        chk("slb_result_expected", (slb_q.size() > 0) ? 32'd1 : 32'd0, 32'd1);
        if (slb_q.size() > 0) begin
          me = slb_q.pop_front();
          chk("slb_cycle", cyc, me.cyc);
          chk("slb_data", oSLB_dt, me.data);
          chk("slb_nick", {28'd0, oSLB_nick}, me.aux);
        end
      end
      if (mem_wr) begin
        chk("write_expected", (wr_q.size() > 0) ? 32'd1 : 32'd0, 32'd1);
        if (wr_q.size() > 0) begin
          me = wr_q.pop_front();
          chk("write_cycle", cyc, me.cyc);
          chk("write_addr", mem_a, me.aux);
          chk("write_data", {24'd0, mem_dout}, me.data);
        end
      end
    end
  end

  initial begin
    int c0;
    for (int i = 0; i < 65536; i++) ram[i] = fill(i);
    ram[16'h1000] = 8'h78;
    ram[16'h1001] = 8'h56;
    ram[16'h1002] = 8'h34;
    ram[16'h1003] = 8'h12;
    rst = 1'b1; rdy = 1'b1; clr = 1'b0;
    iIC_en = 1'b0; iIC_addr = '0;
    iSLB_en = 1'b0; iSLB_ls = 1'b0; iSLB_nick = '0; iSLB_len = '0;
    iSLB_sext = 1'b0; iSLB_addr = '0; iSLB_dt = '0;
    repeat (2) @(posedge clk);
    #1;

    chk("rst_mem_a", mem_a, 32'd0);
    chk("rst_mem_dout", {24'd0, mem_dout}, 32'd0);
    chk("rst_mem_wr", {31'd0, mem_wr}, 32'd0);
    chk("rst_ic_en", {31'd0, oIC_en}, 32'd0);
    chk("rst_slb_en", {31'd0, oSLB_en}, 32'd0);
    chk("rst_ic_busy", {31'd0, oIC_busy}, 32'd0);
    chk("rst_slb_busy", {31'd0, oSLB_busy}, 32'd0);
    chk("rst_ic_dt", oIC_dt, 32'd0);
    chk("rst_slb_dt", oSLB_dt, 32'd0);
    chk("rst_slb_nick", {28'd0, oSLB_nick}, 32'd0);
    rst = 1'b0;
    mon_on = 1'b1;
    next_cycle(2);

    // 4-byte load
    c0 = cyc;
    slb_req(1'b0, 2'd2, 1'b0, 4'd5, 32'h1000, 32'h0);
    exp_slb(c0 + 6, 32'h12345678, 32'd5);
    next_cycle();
    for (int k = 0; k < 4; k++) begin
      chk("load_addr", mem_a, 32'h1000 + k);
      if (k == 0) chk("load_busy_rise", {31'd0, oSLB_busy}, 32'd1);
      next_cycle();
    end
    chk("load_busy_held", {31'd0, oSLB_busy}, 32'd1);
    next_cycle();
    chk("load_busy_fall", {31'd0, oSLB_busy}, 32'd0);
    next_cycle(2);

    // Sign/zero extension
    ram[16'h1003] = 8'h80;
    c0 = cyc;
    slb_req(1'b0, 2'd0, 1'b1, 4'd3, 32'h1003, 32'h0);
    exp_slb(c0 + 3, 32'hFFFFFF80, 32'd3);
    next_cycle(4);
    c0 = cyc;
    slb_req(1'b0, 2'd0, 1'b0, 4'd4, 32'h1003, 32'h0);
    exp_slb(c0 + 3, 32'h00000080, 32'd4);
    next_cycle(4);
    c0 = cyc;
    slb_req(1'b0, 2'd1, 1'b1, 4'd6, 32'h1002, 32'h0);
    exp_slb(c0 + 4, 32'hFFFF8034, 32'd6);
    next_cycle(5);

    // Fetch across the top of the address space
    c0 = cyc;
    ic_req(32'hFFFF_FFFE);
    exp_ic(c0 + 6, {ram[16'h0001], ram[16'h0000], ram[16'hFFFF], ram[16'hFFFE]});
    next_cycle();
    chk("wrap_addr0", mem_a, 32'hFFFF_FFFE);
    next_cycle();
    chk("wrap_addr1", mem_a, 32'hFFFF_FFFF);
    next_cycle();
    chk("wrap_addr2", mem_a, 32'h0000_0000);
    next_cycle(5);

    // Store halfword
    c0 = cyc;
    slb_req(1'b1, 2'd1, 1'b0, 4'd0, 32'h2002, 32'h0000BEEF);
    exp_wr(c0 + 1, 32'h2002, 8'hEF);
    exp_wr(c0 + 2, 32'h2003, 8'hBE);
    next_cycle(2);
    chk("store_busy_held", {31'd0, oSLB_busy}, 32'd1);
    next_cycle();
    chk("store_busy_fall", {31'd0, oSLB_busy}, 32'd0);
    next_cycle(2);

    // Round-robin from reset: SLB first, then IC, then queued SLB; next tie goes to IC
    rst = 1'b1;
    next_cycle();
    rst = 1'b0;
    next_cycle();
    c0 = cyc;
    ic_req(32'h3000);
    slb_req(1'b0, 2'd0, 1'b0, 4'd1, 32'h1000, 32'h0);
    exp_slb(c0 + 3, 32'h00000078, 32'd1);
    exp_ic(c0 + 8, ram_word(32'h3000));
    next_cycle();
    chk("tie_slb_first", mem_a, 32'h1000);
    next_cycle(2);
    chk("ic_after_slb", mem_a, 32'h3000);
    next_cycle();
    slb_req(1'b0, 2'd1, 1'b0, 4'd2, 32'h1000, 32'h0);
    exp_slb(c0 + 11, 32'h00005678, 32'd2);
    next_cycle(4);
    chk("queued_slb_after_ic", mem_a, 32'h1000);
    next_cycle(5);
    c0 = cyc;
    ic_req(32'h3004);
    slb_req(1'b0, 2'd0, 1'b0, 4'd7, 32'h1001, 32'h0);
    exp_ic(c0 + 6, ram_word(32'h3004));
    exp_slb(c0 + 8, 32'h00000056, 32'd7);
    next_cycle();
    chk("tie_ic_second", mem_a, 32'h3004);
    next_cycle(8);

    // Flush mid-fetch while a store waits
    c0 = cyc;
    ic_req(32'h3010);
    next_cycle();
    slb_req(1'b1, 2'd2, 1'b0, 4'd0, 32'h4000, 32'hDEADBEEF);
    next_cycle(2);
    clr = 1'b1;
    exp_wr(c0 + 4, 32'h4000, 8'hEF);
    exp_wr(c0 + 5, 32'h4001, 8'hBE);
    exp_wr(c0 + 6, 32'h4002, 8'hAD);
    exp_wr(c0 + 7, 32'h4003, 8'hDE);
    next_cycle();
    chk("clr_ic_busy", {31'd0, oIC_busy}, 32'd0);
    chk("clr_store_kept", {31'd0, oSLB_busy}, 32'd1);
    next_cycle(6);

    // rdy freeze during a load: result moves out by exactly three cycles
    c0 = cyc;
    slb_req(1'b0, 2'd2, 1'b0, 4'd9, 32'h1000, 32'h0);
    exp_slb(c0 + 9, 32'h80345678, 32'd9);
    next_cycle(2);
    rdy = 1'b0;
    chk("freeze_addr_a", mem_a, 32'h1001);
    next_cycle();
    chk("freeze_addr_b", mem_a, 32'h1001);
    chk("freeze_no_wr", {31'd0, mem_wr}, 32'd0);
    next_cycle();
    chk("freeze_addr_c", mem_a, 32'h1001);
    next_cycle();
    rdy = 1'b1;
    next_cycle(6);

    // rdy freeze during a store: write strobe masked, byte resumes afterwards
    c0 = cyc;
    slb_req(1'b1, 2'd1, 1'b0, 4'd0, 32'h5000, 32'h00001234);
    exp_wr(c0 + 1, 32'h5000, 8'h34);
    exp_wr(c0 + 3, 32'h5001, 8'h12);
    next_cycle(2);
    rdy = 1'b0;
    #1;
    chk("freeze_store_wr", {31'd0, mem_wr}, 32'd0);
    chk("freeze_store_addr", mem_a, 32'h5001);
    next_cycle();
    rdy = 1'b1;
    next_cycle(3);

    // Reset in the middle of a store
    c0 = cyc;
    slb_req(1'b1, 2'd2, 1'b0, 4'd0, 32'h6000, 32'h11223344);
    exp_wr(c0 + 1, 32'h6000, 8'h44);
    exp_wr(c0 + 2, 32'h6001, 8'h33);
    next_cycle(3);
    rst = 1'b1;
    #1;
    chk("midrst_mem_wr", {31'd0, mem_wr}, 32'd0);
    chk("midrst_mem_a", mem_a, 32'd0);
    chk("midrst_mem_dout", {24'd0, mem_dout}, 32'd0);
    chk("midrst_slb_busy", {31'd0, oSLB_busy}, 32'd0);
    chk("midrst_ic_busy", {31'd0, oIC_busy}, 32'd0);
    next_cycle();
    rst = 1'b0;
    next_cycle(4);

    chk("ic_results_drained", ic_q.size(), 32'd0);
    chk("slb_results_drained", slb_q.size(), 32'd0);
    chk("writes_drained", wr_q.size(), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
